// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and constants for the common data bus producer.
// Tag 0 is reserved to mean "no broadcast".
package cdb_broadcaster_pkg;

    localparam int unsigned CDB_NUM_FU = 4;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned TAG_W      = 4;
    localparam int unsigned ROB_SZ     = (1 << TAG_W) - 1;

    typedef logic [TAG_W-1:0] rob_tag_t;
    typedef logic [XLEN-1:0]  cdb_value_t;

    // One buffered functional-unit result
    typedef struct packed {
        rob_tag_t   rob_tag;
        cdb_value_t value;
    } fu_result_t;

    // Broadcast payload seen by ROB, reservation stations and map table
    typedef struct packed {
        logic       valid;
        rob_tag_t   rob_tag;
        cdb_value_t value;
    } cdb_packet_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Two-entry per-FU result FIFO with occupancy count; flush empties it.
// Head, ready and nonempty are combinational views of registered state.
module cdb_fu_fifo
    import cdb_broadcaster_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  fu_result_t din,
    output fu_result_t head_c,
    output logic       ready_c,
    output logic       nonempty_c
);

    logic [1:0] count;
    logic       head_ptr;
    logic       tail_ptr;
    fu_result_t mem [2];

    assign ready_c    = (count != 2'd2);
    assign nonempty_c = (count != 2'd0);
    assign head_c     = mem[head_ptr];

    // Occupancy and pointers; push+pop together leaves count unchanged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= 2'd0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
        end else if (flush) begin
            count    <= 2'd0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
        end else begin
            if (push) tail_ptr <= ~tail_ptr;
            if (pop)  head_ptr <= ~head_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; count guards visibility
    always_ff @(posedge clock) begin
        if (push && !flush) mem[tail_ptr] <= din;
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus producer: per-FU 2-entry FIFOs, round-robin arbiter, registered broadcast.
// Optional CDB_SQUASH_EN makes the squash input flush all FIFOs and the bus.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int unsigned NUM_FU = CDB_NUM_FU
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_FU-1:0]            fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0] fu_rob_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0]  fu_value,
    output logic [NUM_FU-1:0]            fu_ready,
    input  logic                         squash,
    output logic                         cdb_valid,
    output logic [TAG_W-1:0]             cdb_rob_tag,
    output logic [XLEN-1:0]              cdb_value
);

    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic flush;
`ifdef CDB_SQUASH_EN
    assign flush = squash;
`else
    logic unused_squash;
    assign flush         = 1'b0;
    assign unused_squash = squash;
`endif

    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] nonempty;
    fu_result_t        din  [NUM_FU];
    fu_result_t        head [NUM_FU];

    // Tag-0 offers complete the handshake but are never stored
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
        assign push[gi] = fu_valid[gi] && fu_ready[gi] && (fu_rob_tag[gi] != '0);
        assign din[gi]  = '{rob_tag: fu_rob_tag[gi], value: fu_value[gi]};

        cdb_fu_fifo u_fifo (
            .clock      (clock),
            .reset      (reset),
            .flush      (flush),
            .push       (push[gi]),
            .pop        (pop[gi]),
            .din        (din[gi]),
            .head_c     (head[gi]),
            .ready_c    (fu_ready[gi]),
            .nonempty_c (nonempty[gi])
        );
    end

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_next;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_valid;
    int unsigned      idx;
    cdb_packet_t      cdb_q;
    cdb_packet_t      cdb_next;

    // Round-robin search starting at rr_ptr over nonempty FIFOs
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_FU;
            if (!grant_valid && nonempty[PTR_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        pop      = '0;
        rr_next  = rr_ptr;
        cdb_next = '0;
        if (grant_valid) begin
            pop[grant_idx]   = 1'b1;
            rr_next          = PTR_W'((32'(grant_idx) + 1) % NUM_FU);
            cdb_next.valid   = 1'b1;
            cdb_next.rob_tag = head[grant_idx].rob_tag;
            cdb_next.value   = head[grant_idx].value;
        end
    end

    // Broadcast register and arbitration pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            cdb_q  <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
            cdb_q  <= '0;
        end else begin
            rr_ptr <= rr_next;
            cdb_q  <= cdb_next;
        end
    end

    assign cdb_valid   = cdb_q.valid;
    assign cdb_rob_tag = cdb_q.rob_tag;
    assign cdb_value   = cdb_q.value;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed self-checking bench for cdb_broadcaster.
// Squash scenario expectations follow CDB_SQUASH_EN.
module tb_cdb_broadcaster;
    import cdb_broadcaster_pkg::*;

    localparam int unsigned NFU = 4;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NFU-1:0]            fu_valid;
    logic [NFU-1:0][TAG_W-1:0] fu_rob_tag;
    logic [NFU-1:0][XLEN-1:0]  fu_value;
    logic [NFU-1:0]            fu_ready;
    logic                      squash;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_rob_tag;
    logic [XLEN-1:0]           cdb_value;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cdb_broadcaster #(.NUM_FU(NFU)) dut (
        .clock       (clock),
        .reset       (reset),
        .fu_valid    (fu_valid),
        .fu_rob_tag  (fu_rob_tag),
        .fu_value    (fu_value),
        .fu_ready    (fu_ready),
        .squash      (squash),
        .cdb_valid   (cdb_valid),
        .cdb_rob_tag (cdb_rob_tag),
        .cdb_value   (cdb_value)
    );

    function automatic logic [XLEN-1:0] val_of(input int t);
        return 32'hC0DE_0000 | XLEN'(t);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        fu_valid   = '0;
        fu_rob_tag = '0;
        fu_value   = '0;
        squash     = 1'b0;
    endtask

    task automatic offer(input int fu, input int tag);
        fu_valid[fu]   = 1'b1;
        fu_rob_tag[fu] = TAG_W'(tag);
        fu_value[fu]   = val_of(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0 || cdb_value !== '0) begin
            errors++;
            $display("FAIL reset_bus got v=%0b tag=%0d val=%h want 0/0/0", cdb_valid, cdb_rob_tag, cdb_value);
        end
        checks++;
        if (fu_ready !== 4'hF) begin
            errors++;
            $display("FAIL reset_ready got %b want 1111", fu_ready);
        end
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (cdb_valid !== 1'b0 || fu_ready !== 4'hF) begin
            errors++;
            $display("FAIL post_reset got v=%0b ready=%b want 0/1111", cdb_valid, fu_ready);
        end
    endtask

    task automatic test_single_result();
        int exp_bus [4] = '{0, 3, 0, 0};
        logic [XLEN-1:0] ev;
        fu_valid[1]   = 1'b1;
        fu_rob_tag[1] = 4'd3;
        fu_value[1]   = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            idle_inputs();
            ev = (exp_bus[i] != 0) ? 32'hDEAD_BEEF : '0;
            checks++;
            if (cdb_valid !== (exp_bus[i] != 0) || cdb_rob_tag !== TAG_W'(exp_bus[i]) || cdb_value !== ev) begin
                errors++;
                $display("FAIL single[%0d] got v=%0b tag=%0d val=%h want tag=%0d val=%h",
                         i, cdb_valid, cdb_rob_tag, cdb_value, exp_bus[i], ev);
            end
        end
    endtask

    task automatic test_fairness();
        int et;
        logic [XLEN-1:0] ev;
        do_reset();
        for (int f = 0; f < 4; f++) offer(f, f + 1);
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL fair_first got v=%0b want 0", cdb_valid);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            et = (i % 4) + 1;
            ev = val_of(et);
            checks++;
            if (cdb_valid !== 1'b1 || cdb_rob_tag !== TAG_W'(et) || cdb_value !== ev) begin
                errors++;
                $display("FAIL fair[%0d] got v=%0b tag=%0d val=%h want tag=%0d val=%h",
                         i, cdb_valid, cdb_rob_tag, cdb_value, et, ev);
            end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int             exp_bus   [10] = '{1, 2, 3, 5, 9, 10, 11, 6, 7, 0};
        logic [NFU-1:0] exp_ready [10] = '{4'b0011, 4'b0110, 4'b1110, 4'b1111, 4'b1110,
                                           4'b1110, 4'b1110, 4'b1111, 4'b1111, 4'b1111};
        int             drive0    [10] = '{6, 7, 7, 7, 0, 0, 0, 0, 0, 0};
        logic [XLEN-1:0] ev;
        do_reset();
        offer(1, 1); offer(2, 2); offer(3, 3);
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_first got v=%0b want 0", cdb_valid);
        end
        idle_inputs();
        offer(0, 5); offer(1, 9); offer(2, 10); offer(3, 11);
        for (int i = 0; i < 10; i++) begin
            step();
            ev = (exp_bus[i] != 0) ? val_of(exp_bus[i]) : '0;
            checks++;
            if (cdb_valid !== (exp_bus[i] != 0) || cdb_rob_tag !== TAG_W'(exp_bus[i]) || cdb_value !== ev) begin
                errors++;
                $display("FAIL bp_bus[%0d] got v=%0b tag=%0d val=%h want tag=%0d val=%h",
                         i, cdb_valid, cdb_rob_tag, cdb_value, exp_bus[i], ev);
            end
            checks++;
            if (fu_ready !== exp_ready[i]) begin
                errors++;
                $display("FAIL bp_ready[%0d] got %b want %b", i, fu_ready, exp_ready[i]);
            end
            idle_inputs();
            if (drive0[i] != 0) offer(0, drive0[i]);
        end
    endtask

    task automatic test_tag0_drop();
        do_reset();
        fu_valid[2]   = 1'b1;
        fu_rob_tag[2] = '0;
        fu_value[2]   = 32'h0000_1234;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (fu_ready !== 4'hF) begin
                errors++;
                $display("FAIL tag0_ready[%0d] got %b want 1111", i, fu_ready);
            end
            step();
            if (i == 2) idle_inputs();
            checks++;
            if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0 || cdb_value !== '0) begin
                errors++;
                $display("FAIL tag0_bus[%0d] got v=%0b tag=%0d val=%h want 0/0/0", i, cdb_valid, cdb_rob_tag, cdb_value);
            end
        end
    endtask

    task automatic test_squash();
`ifdef CDB_SQUASH_EN
        int             exp_bus [6] = '{0, 0, 0, 0, 0, 0};
        logic [NFU-1:0] exp_rdy     = 4'b1111;
`else
        int             exp_bus [6] = '{2, 3, 4, 5, 6, 0};
        logic [NFU-1:0] exp_rdy     = 4'b0111;
`endif
        int exp_new [3] = '{0, 8, 0};
        logic [XLEN-1:0] ev;
        do_reset();
        offer(0, 1); offer(1, 2); offer(3, 3);
        step();
        idle_inputs();
        offer(0, 4); offer(1, 5); offer(3, 6);
        step();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd1) begin
            errors++;
            $display("FAIL sq_pre got v=%0b tag=%0d want 1/1", cdb_valid, cdb_rob_tag);
        end
        idle_inputs();
        squash = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            squash = 1'b0;
            if (i == 0) begin
                checks++;
                if (fu_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL sq_ready got %b want %b", fu_ready, exp_rdy);
                end
            end
            ev = (exp_bus[i] != 0) ? val_of(exp_bus[i]) : '0;
            checks++;
            if (cdb_valid !== (exp_bus[i] != 0) || cdb_rob_tag !== TAG_W'(exp_bus[i]) || cdb_value !== ev) begin
                errors++;
                $display("FAIL sq_bus[%0d] got v=%0b tag=%0d val=%h want tag=%0d val=%h",
                         i, cdb_valid, cdb_rob_tag, cdb_value, exp_bus[i], ev);
            end
        end
        offer(2, 8);
        for (int i = 0; i < 3; i++) begin
            step();
            idle_inputs();
            ev = (exp_new[i] != 0) ? val_of(exp_new[i]) : '0;
            checks++;
            if (cdb_valid !== (exp_new[i] != 0) || cdb_rob_tag !== TAG_W'(exp_new[i]) || cdb_value !== ev) begin
                errors++;
                $display("FAIL sq_new[%0d] got v=%0b tag=%0d val=%h want tag=%0d val=%h",
                         i, cdb_valid, cdb_rob_tag, cdb_value, exp_new[i], ev);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int exp_new [3] = '{0, 9, 0};
        logic [XLEN-1:0] ev;
        do_reset();
        for (int f = 0; f < 4; f++) offer(f, f + 1);
        step();
        step();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd1) begin
            errors++;
            $display("FAIL mid_pre got v=%0b tag=%0d want 1/1", cdb_valid, cdb_rob_tag);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0 || cdb_value !== '0 || fu_ready !== 4'hF) begin
            errors++;
            $display("FAIL mid_async got v=%0b tag=%0d val=%h ready=%b want 0/0/0/1111",
                     cdb_valid, cdb_rob_tag, cdb_value, fu_ready);
        end
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0 || fu_ready !== 4'hF) begin
                errors++;
                $display("FAIL mid_stale[%0d] got v=%0b tag=%0d ready=%b want 0/0/1111",
                         i, cdb_valid, cdb_rob_tag, fu_ready);
            end
        end
        offer(3, 9);
        for (int i = 0; i < 3; i++) begin
            step();
            idle_inputs();
            ev = (exp_new[i] != 0) ? val_of(exp_new[i]) : '0;
            checks++;
            if (cdb_valid !== (exp_new[i] != 0) || cdb_rob_tag !== TAG_W'(exp_new[i]) || cdb_value !== ev) begin
                errors++;
                $display("FAIL mid_new[%0d] got v=%0b tag=%0d val=%h want tag=%0d val=%h",
                         i, cdb_valid, cdb_rob_tag, cdb_value, exp_new[i], ev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_result();
        test_fairness();
        test_backpressure();
        test_tag0_drop();
        test_squash();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
